// File: rtl/s_ram_pkg.sv
// Shared types and constants for the s_RAM arbiter slice.
// Requester indices match the cipher phases that share the s_RAM.
package s_ram_pkg;

    localparam int AW_DEF = 8;
    localparam int DW_DEF = 8;

    localparam int REQ_INIT = 0;
    localparam int REQ_KSA  = 1;
    localparam int REQ_PRGA = 2;

    // Owner field is wide enough for any practical requester count.
    localparam int OW = 8;

    typedef struct packed {
        logic          valid;
        logic [OW-1:0] owner;
    } tag_t;

endpackage

// File: rtl/s_ram_arbiter_if.sv
// Requester and s_RAM bus bundle for the arbiter.
// master is the arbiter side, slave is the requesters/RAM side.
interface s_ram_arbiter_if
    import s_ram_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF
);

    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ*AW-1:0] req_address;
    logic [NUM_REQ*DW-1:0] req_data;
    logic [NUM_REQ-1:0]    req_wren;
    logic [NUM_REQ-1:0]    gnt;

    logic [AW-1:0]         ram_address;
    logic [DW-1:0]         ram_data;
    logic                  ram_wren;
    logic [DW-1:0]         ram_q;

    logic [NUM_REQ-1:0]    rd_valid;
    logic [DW-1:0]         rd_data;
    logic                  busy;

    modport master (
        input  req, req_address, req_data, req_wren, ram_q,
        output gnt, ram_address, ram_data, ram_wren,
        output rd_valid, rd_data, busy
    );

    modport slave (
        output req, req_address, req_data, req_wren, ram_q,
        input  gnt, ram_address, ram_data, ram_wren,
        input  rd_valid, rd_data, busy
    );

endinterface

// File: rtl/s_ram_arbiter_rd_tag_pipe.sv
// Read-return tag delay line, RD_LAT stages of {valid, owner}.
// Lines a returning read up with the s_RAM output for its owner.
module rd_tag_pipe
    import s_ram_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic clock,
    input  logic reset,
    input  tag_t tag_in,
    output tag_t tag_out
);

    tag_t stage [RD_LAT];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < RD_LAT; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= tag_in;
            for (int i = 1; i < RD_LAT; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign tag_out = stage[RD_LAT-1];

endmodule

// File: rtl/s_ram_arbiter.sv
// Round-robin s_RAM arbiter with burst ownership lock and
// tagged read-return routing back to the issuing requester.
module s_ram_arbiter
    import s_ram_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF,
    parameter int RD_LAT  = 1
) (
    input logic              clock,
    input logic              reset,
    s_ram_arbiter_if.master  bus
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0] gnt_q;
    logic [NUM_REQ-1:0] gnt_nxt;
    logic [NUM_REQ-1:0] gnt;
    logic [NUM_REQ-1:0] active;
    logic [IW-1:0]      last_owner;
    logic [IW-1:0]      own_idx;
    logic [IW-1:0]      pick_idx;
    logic [IW-1:0]      cand;
    logic               lock;
    logic               pick_ok;
    logic               wren_mux;
    tag_t               tag_in;
    tag_t               tag_out;

    // Reset masks the registered grant so nothing leaks during reset.
    assign gnt    = gnt_q & {NUM_REQ{~reset}};
    assign active = gnt & bus.req;
    assign lock   = |active;

    always_comb begin
        own_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (gnt[k]) begin
                own_idx = IW'(k);
            end
        end
    end

    // Walk backwards so the requester nearest last_owner wins.
    always_comb begin
        pick_ok  = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand = IW'((int'(last_owner) + i) % NUM_REQ);
            if (bus.req[cand]) begin
                pick_ok  = 1'b1;
                pick_idx = cand;
            end
        end
    end

    always_comb begin
        gnt_nxt = '0;
        if (lock) begin
            gnt_nxt = gnt;
        end else if (pick_ok) begin
            gnt_nxt[pick_idx] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            gnt_q      <= '0;
            last_owner <= IW'(NUM_REQ - 1);
        end else begin
            gnt_q <= gnt_nxt;
            if (!lock && pick_ok) begin
                last_owner <= pick_idx;
            end
        end
    end

    always_comb begin
        bus.ram_address = '0;
        bus.ram_data    = '0;
        wren_mux        = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (active[k]) begin
                bus.ram_address = bus.req_address[k*AW +: AW];
                bus.ram_data    = bus.req_data[k*DW +: DW];
                wren_mux        = bus.req_wren[k];
            end
        end
    end

    assign bus.ram_wren = wren_mux;
    assign bus.gnt      = gnt;
    assign bus.busy     = |gnt;

    assign tag_in.valid = lock & ~wren_mux;
    assign tag_in.owner = OW'(own_idx);

    rd_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_tag_pipe (
        .clock   (clock),
        .reset   (reset),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    always_comb begin
        bus.rd_valid = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            bus.rd_valid[k] = ~reset & tag_out.valid
                            & (tag_out.owner == OW'(k));
        end
    end

    assign bus.rd_data = bus.ram_q;

endmodule

// File: tb/tb_s_ram_arbiter.sv
// Bench for s_ram_arbiter: RD_LAT=1 and RD_LAT=2 instances share stimulus.
// A queue-based reference model predicts every output each cycle.
module tb_s_ram_arbiter;
    import s_ram_pkg::*;

    localparam int N  = 3;
    localparam int AW = 8;
    localparam int DW = 8;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    s_ram_arbiter_if #(.NUM_REQ(N), .AW(AW), .DW(DW)) b1 ();
    s_ram_arbiter_if #(.NUM_REQ(N), .AW(AW), .DW(DW)) b2 ();

    assign b2.req         = b1.req;
    assign b2.req_address = b1.req_address;
    assign b2.req_data    = b1.req_data;
    assign b2.req_wren    = b1.req_wren;
    assign b2.ram_q       = b1.ram_q;

    s_ram_arbiter #(.NUM_REQ(N), .AW(AW), .DW(DW), .RD_LAT(1)) dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (b1)
    );

    s_ram_arbiter #(.NUM_REQ(N), .AW(AW), .DW(DW), .RD_LAT(2)) dut2 (
        .clock (clock),
        .reset (reset),
        .bus   (b2)
    );

    int n_tests = 0;
    int n_fail  = 0;

    int m_owner;
    int m_last;
    int h1[$];
    int h2[$];

    typedef struct {
        logic [N-1:0] req;
        logic [N-1:0] wren;
        logic [N-1:0] gnt;
        logic         ram_wren;
    } vec_t;

    vec_t tbl[9];

    function automatic void cmp(string nm, logic [31:0] act,
                                logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endfunction

    function automatic bit reqbit(int k);
        return bit'(b1.req >> k);
    endfunction

    function automatic void model_reset();
        m_owner = -1;
        m_last  = N - 1;
        h1.delete();
        h2.delete();
        h1.push_back(-1);
        h2.push_back(-1);
        h2.push_back(-1);
    endfunction

    task automatic check_outputs();
        logic [N-1:0]  eg, e1, e2;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        logic          ew;
        bit            act;
        eg = '0; e1 = '0; e2 = '0;
        ea = '0; ed = '0; ew = 1'b0; act = 1'b0;
        if (!reset) begin
            if (m_owner >= 0) begin
                eg  = N'(1) << m_owner;
                act = reqbit(m_owner);
            end
            if (act) begin
                ea = AW'(b1.req_address >> (m_owner * AW));
                ed = DW'(b1.req_data >> (m_owner * DW));
                ew = bit'(b1.req_wren >> m_owner);
            end
            if (h1[0] >= 0) e1 = N'(1) << h1[0];
            if (h2[0] >= 0) e2 = N'(1) << h2[0];
        end
        cmp("gnt", 32'(b1.gnt), 32'(eg));
        cmp("gnt_lat2", 32'(b2.gnt), 32'(eg));
        cmp("busy", 32'(b1.busy), 32'(eg != 0));
        cmp("ram_address", 32'(b1.ram_address), 32'(ea));
        cmp("ram_data", 32'(b1.ram_data), 32'(ed));
        cmp("ram_wren", 32'(b1.ram_wren), 32'(ew));
        cmp("ram_wren_lat2", 32'(b2.ram_wren), 32'(ew));
        cmp("rd_valid_lat1", 32'(b1.rd_valid), 32'(e1));
        cmp("rd_valid_lat2", 32'(b2.rd_valid), 32'(e2));
        cmp("rd_data_lat1", 32'(b1.rd_data), 32'(b1.ram_q));
        cmp("rd_data_lat2", 32'(b2.rd_data), 32'(b1.ram_q));
    endtask

    // Apply the arbitration rules to the inputs seen at this edge.
    task automatic model_edge();
        int  tag;
        bit  act;
        if (reset) begin
            model_reset();
        end else begin
            act = (m_owner >= 0) && reqbit(m_owner);
            tag = -1;
            if (act && !bit'(b1.req_wren >> m_owner)) tag = m_owner;
            void'(h1.pop_front());
            h1.push_back(tag);
            void'(h2.pop_front());
            h2.push_back(tag);
            if (!act) begin
                m_owner = -1;
                for (int i = 1; i <= N; i++) begin
                    int c;
                    c = (m_last + i) % N;
                    if (reqbit(c)) begin
                        m_owner = c;
                        m_last  = c;
                        break;
                    end
                end
            end
        end
    endtask

    task automatic pre();
        #3;
        check_outputs();
    endtask

    task automatic post();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic cycle();
        pre();
        post();
    endtask

    task automatic idle();
        b1.req         = '0;
        b1.req_wren    = '0;
        b1.req_address = '0;
        b1.req_data    = '0;
        b1.ram_q       = '0;
    endtask

    task automatic do_reset(int n);
        reset = 1'b1;
        idle();
        for (int i = 0; i < n; i++) cycle();
        reset = 1'b0;
    endtask

    initial begin
        model_reset();
        reset = 1'b1;
        idle();

        tbl[0] = '{3'b111, 3'b000, 3'b000, 1'b0};
        tbl[1] = '{3'b111, 3'b001, 3'b001, 1'b1};
        tbl[2] = '{3'b110, 3'b000, 3'b001, 1'b0};
        tbl[3] = '{3'b110, 3'b000, 3'b010, 1'b0};
        tbl[4] = '{3'b100, 3'b000, 3'b010, 1'b0};
        tbl[5] = '{3'b101, 3'b100, 3'b100, 1'b1};
        tbl[6] = '{3'b001, 3'b100, 3'b100, 1'b0};
        tbl[7] = '{3'b000, 3'b000, 3'b001, 1'b0};
        tbl[8] = '{3'b000, 3'b000, 3'b000, 1'b0};

        do_reset(2);

        // Handover chain and write suppression when owner is idle.
        for (int r = 0; r < 9; r++) begin
            b1.req      = tbl[r].req;
            b1.req_wren = tbl[r].wren;
            for (int k = 0; k < N; k++) begin
                b1.req_address[k*AW +: AW] = 8'((k << 4) + r);
                b1.req_data[k*DW +: DW]    = 8'(8'hA0 + (k << 2) + r);
            end
            pre();
            cmp("tbl_gnt", 32'(b1.gnt), 32'(tbl[r].gnt));
            cmp("tbl_wren", 32'(b1.ram_wren), 32'(tbl[r].ram_wren));
            cmp("tbl_busy", 32'(b1.busy), 32'(tbl[r].gnt != 0));
            post();
        end

        // Long write burst from requester 0 with everyone requesting.
        do_reset(1);
        b1.req      = 3'b111;
        b1.req_wren = 3'b111;
        cycle();
        for (int i = 0; i < 256; i++) begin
            b1.req_address[REQ_INIT*AW +: AW] = 8'(i);
            b1.req_address[REQ_KSA*AW +: AW]  = 8'(255 - i);
            pre();
            cmp("burst_gnt", 32'(b1.gnt), 32'(3'b001));
            cmp("burst_addr", 32'(b1.ram_address), 32'(i));
            post();
        end
        idle();
        cycle();
        cycle();

        // Read by requester 1 returning 5C after one and two cycles.
        b1.req = 3'b010;
        b1.req_address[REQ_KSA*AW +: AW] = 8'h2A;
        cycle();
        pre();
        cmp("rd_gnt", 32'(b1.gnt), 32'(3'b010));
        cmp("rd_addr", 32'(b1.ram_address), 32'(8'h2A));
        post();
        b1.req   = '0;
        b1.ram_q = 8'h5C;
        pre();
        cmp("rv1_at1", 32'(b1.rd_valid), 32'(3'b010));
        cmp("rd1_at1", 32'(b1.rd_data), 32'(8'h5C));
        cmp("rv2_at1", 32'(b2.rd_valid), 32'(3'b000));
        post();
        pre();
        cmp("rv2_at2", 32'(b2.rd_valid), 32'(3'b010));
        cmp("rd2_at2", 32'(b2.rd_data), 32'(8'h5C));
        cmp("rv1_at2", 32'(b1.rd_valid), 32'(3'b000));
        post();
        idle();
        cycle();

        // Read at FF right before handing the bus from 0 to 1.
        b1.req = 3'b001;
        cycle();
        b1.req = 3'b011;
        b1.req_address[REQ_INIT*AW +: AW] = 8'hFF;
        pre();
        cmp("ho_gnt_old", 32'(b1.gnt), 32'(3'b001));
        post();
        b1.req = 3'b010;
        pre();
        cmp("ho_rv1", 32'(b1.rd_valid), 32'(3'b001));
        post();
        pre();
        cmp("ho_gnt_new", 32'(b2.gnt), 32'(3'b010));
        cmp("ho_rv2", 32'(b2.rd_valid), 32'(3'b001));
        post();
        idle();
        cycle();
        cycle();

        // Reset lands on top of an outstanding read.
        b1.req = 3'b100;
        b1.req_address[REQ_PRGA*AW +: AW] = 8'h11;
        cycle();
        cycle();
        reset = 1'b1;
        pre();
        cmp("rst_rv1", 32'(b1.rd_valid), 32'(0));
        post();
        reset  = 1'b0;
        b1.req = '0;
        pre();
        cmp("rst_gnt", 32'(b1.gnt), 32'(0));
        cmp("rst_rv2", 32'(b2.rd_valid), 32'(0));
        post();

        // Random traffic with bursty requests and rare resets.
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(99) == 0);
            for (int k = 0; k < N; k++) begin
                if (b1.req[k]) begin
                    if ($urandom_range(7) == 0) b1.req[k] = 1'b0;
                end else if ($urandom_range(3) == 0) begin
                    b1.req[k] = 1'b1;
                end
            end
            b1.req_wren    = N'($urandom);
            b1.req_address = (N*AW)'({$urandom, $urandom});
            b1.req_data    = (N*DW)'({$urandom, $urandom});
            b1.ram_q       = DW'($urandom);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
